// File: rtl/waveform_player.sv
// Waveform player: the host loads a sample table, and each trigger edge then streams one entry to wave_data.
// Defining WAVE_OVERRUN_CNT_EN adds a saturating count of trigger edges dropped during a fetch.
module waveform_player #(
    parameter logic [3:0] ADDR_SPACE = 4'h8,
    parameter int         IDX_WIDTH  = 10
) (
    input  logic        clkbuffer,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic [31:0] wave_data,
    output logic        wave_valid,
    output logic        wave_active,
    output logic [15:0] wave_status
);
    localparam int DEPTH = 1 << IDX_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        FETCH     = 2'd2,
        OUTPUT    = 2'd3
    } state_t;

    state_t               state_r;
    logic [31:0]          ram_r [DEPTH];
    logic [31:0]          doutb_r;
    logic [IDX_WIDTH-1:0] rd_index_r;
    logic [IDX_WIDTH-1:0] last_index_r;
    logic                 loop_r;
    logic                 done_r;
    logic                 trig_meta_r;
    logic                 trig_sync_r;
    logic                 trig_prev_r;
    logic                 trig_pulse_s;
    logic                 tbl_wr_s;
    logic                 ctrl_wr_s;
    logic                 start_s;
    logic                 stop_s;
    logic                 rd_en_s;
    logic [7:0]           ovr_s;
    logic [9:0]           rd_index10_s;
    logic [9:0]           last_index10_s;
    logic                 unused_s;

    assign trig_pulse_s   = trig_sync_r & ~trig_prev_r;
    assign rd_index10_s   = 10'(rd_index_r);
    assign last_index10_s = 10'(last_index_r);
    assign wave_status    = {wave_active, loop_r, done_r, 3'b000, last_index10_s};
    assign unused_s       = ^reg_wdata[28:IDX_WIDTH];

    // Host write decode and playback read request.
    always_comb begin
        tbl_wr_s  = 1'b0;
        ctrl_wr_s = 1'b0;
        if (reg_wen && (reg_waddr[15:12] == ADDR_SPACE)) begin
            tbl_wr_s  = ~reg_waddr[11];
            ctrl_wr_s = (reg_waddr[11:0] == 12'h800);
        end else begin
            tbl_wr_s  = 1'b0;
            ctrl_wr_s = 1'b0;
        end
        stop_s  = ctrl_wr_s & reg_wdata[30];
        start_s = ctrl_wr_s & reg_wdata[31] & ~reg_wdata[30];
        rd_en_s = (state_r == WAIT_TRIG) & trig_pulse_s;
    end

    // Host read mux: only the status word is readable, the table is write-only.
    always_comb begin
        reg_rdata = 32'h0000_0000;
        if ((reg_raddr[15:12] == ADDR_SPACE) && (reg_raddr[11:0] == 12'h800)) begin
            reg_rdata = {ovr_s, wave_active, loop_r, done_r, 1'b0, rd_index10_s, last_index10_s};
        end else begin
            reg_rdata = 32'h0000_0000;
        end
    end

    // Sample table: port A host write, port B registered read-first playback read.
    always_ff @(posedge clkbuffer) begin
        if (tbl_wr_s) begin
            ram_r[reg_waddr[IDX_WIDTH-1:0]] <= reg_wdata;
        end
        if (rd_en_s) begin
            doutb_r <= ram_r[rd_index_r];
        end
    end

    // Trigger synchroniser plus edge-detect history flop.
    always_ff @(posedge clkbuffer) begin
        if (reset) begin
            trig_meta_r <= 1'b0;
            trig_sync_r <= 1'b0;
            trig_prev_r <= 1'b0;
        end else begin
            trig_meta_r <= trigger;
            trig_sync_r <= trig_meta_r;
            trig_prev_r <= trig_sync_r;
        end
    end

    // Playback state machine with registered outputs; stop overrides every state.
    always_ff @(posedge clkbuffer) begin
        if (reset) begin
            state_r      <= IDLE;
            rd_index_r   <= '0;
            last_index_r <= '0;
            loop_r       <= 1'b0;
            done_r       <= 1'b0;
            wave_data    <= 32'h0000_0000;
            wave_valid   <= 1'b0;
            wave_active  <= 1'b0;
        end else begin
            wave_valid <= 1'b0;
            if (ctrl_wr_s && (state_r == IDLE)) begin
                loop_r       <= reg_wdata[29];
                last_index_r <= reg_wdata[IDX_WIDTH-1:0];
            end
            if (stop_s) begin
                state_r     <= IDLE;
                wave_active <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            rd_index_r  <= '0;
                            done_r      <= 1'b0;
                            wave_active <= 1'b1;
                            state_r     <= WAIT_TRIG;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_pulse_s) begin
                            state_r <= FETCH;
                        end
                    end
                    FETCH: begin
                        state_r <= OUTPUT;
                    end
                    OUTPUT: begin
                        wave_data  <= doutb_r;
                        wave_valid <= 1'b1;
                        if (rd_index_r == last_index_r) begin
                            if (loop_r) begin
                                rd_index_r <= '0;
                                state_r    <= WAIT_TRIG;
                            end else begin
                                done_r      <= 1'b1;
                                wave_active <= 1'b0;
                                state_r     <= IDLE;
                            end
                        end else begin
                            rd_index_r <= rd_index_r + IDX_WIDTH'(1);
                            state_r    <= WAIT_TRIG;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef WAVE_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_r;
    logic       drop_s;

    assign drop_s = trig_pulse_s & ((state_r == FETCH) | (state_r == OUTPUT));
    assign ovr_s  = ovr_cnt_r;

    // Saturating count of trigger edges lost because a fetch was still in flight.
    always_ff @(posedge clkbuffer) begin
        if (reset) begin
            ovr_cnt_r <= 8'd0;
        end else if (start_s && (state_r == IDLE)) begin
            ovr_cnt_r <= 8'd0;
        end else if (drop_s && (ovr_cnt_r != 8'hFF)) begin
            ovr_cnt_r <= ovr_cnt_r + 8'd1;
        end
    end
`else
    assign ovr_s = 8'h00;
`endif

endmodule

// File: tb/tb_waveform_player.sv
// Directed bench for waveform_player: a scoreboard queue of expected samples is checked on every wave_valid strobe.
module tb_waveform_player;
    logic        clkbuffer = 1'b0;
    logic        reset     = 1'b1;
    logic        trigger   = 1'b0;
    logic [15:0] reg_waddr = 16'h0000;
    logic [31:0] reg_wdata = 32'h0000_0000;
    logic        reg_wen   = 1'b0;
    logic [15:0] reg_raddr = 16'h8800;
    logic [31:0] reg_rdata;
    logic [31:0] wave_data;
    logic        wave_valid;
    logic        wave_active;
    logic [15:0] wave_status;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_valid  = 0;
    int          valid_mark;
    bit          sb_ignore = 1'b0;
    logic [31:0] sb_q[$];
    logic [7:0]  ovr_one;
    logic [7:0]  ovr_sat;

    waveform_player dut (
        .clkbuffer  (clkbuffer),
        .reset      (reset),
        .trigger    (trigger),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_wen    (reg_wen),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata),
        .wave_data  (wave_data),
        .wave_valid (wave_valid),
        .wave_active(wave_active),
        .wave_status(wave_status)
    );

    always #5 clkbuffer = ~clkbuffer;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard: each strobe must match the oldest queued sample.
    always @(negedge clkbuffer) begin
        if (wave_valid === 1'b1 && !sb_ignore) begin
            n_valid++;
            if (sb_q.size() > 0) begin
                check("wave_data", wave_data, sb_q.pop_front());
            end else begin
                check("unexpected_valid", {31'b0, wave_valid}, 32'h0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clkbuffer);
        #1;
    endtask

    task automatic reg_write(input logic [15:0] addr, input logic [31:0] data);
        reg_waddr = addr;
        reg_wdata = data;
        reg_wen   = 1'b1;
        tick(1);
        reg_wen   = 1'b0;
    endtask

    // One trigger edge that must be played; also checks the 4-edge latency.
    task automatic trig_expect(input logic [31:0] exp_data);
        sb_q.push_back(exp_data);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(3);
        check("latency_early", {31'b0, wave_valid}, 32'h0);
        tick(1);
        check("latency_valid", {31'b0, wave_valid}, 32'h1);
        tick(15);
    endtask

    initial begin
`ifdef WAVE_OVERRUN_CNT_EN
        ovr_one = 8'd1;
        ovr_sat = 8'd255;
`else
        ovr_one = 8'd0;
        ovr_sat = 8'd0;
`endif
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_data", wave_data, 32'h0);
        check("rst_valid", {31'b0, wave_valid}, 32'h0);
        check("rst_active", {31'b0, wave_active}, 32'h0);
        check("rst_status", {16'h0, wave_status}, 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);

        for (int i = 0; i < 4; i++) begin
            reg_write(16'h8000 + 16'(i), 32'hA0 + 32'(i));
        end
        reg_raddr = 16'h8001;
        #1;
        check("table_read_zero", reg_rdata, 32'h0);
        reg_raddr = 16'h8800;

        // One-shot playback of four entries.
        reg_write(16'h8800, 32'h8000_0003);
        check("start_active", {31'b0, wave_active}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            trig_expect(32'hA0 + 32'(i));
        end
        check("oneshot_active", {31'b0, wave_active}, 32'h0);
        check("oneshot_status", {16'h0, wave_status}, 32'h0000_2003);
        check("oneshot_rdata", reg_rdata, 32'h0020_0C03);

        // Looping playback over two entries.
        reg_write(16'h8800, 32'hA000_0001);
        trig_expect(32'hA0);
        trig_expect(32'hA1);
        trig_expect(32'hA0);
        trig_expect(32'hA1);
        trig_expect(32'hA0);
        check("loop_status", {16'h0, wave_status}, 32'h0000_C001);

        // Stop while the sample is in flight suppresses it.
        valid_mark = n_valid;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(1);
        reg_write(16'h8800, 32'h4000_0000);
        check("stop_active", {31'b0, wave_active}, 32'h0);
        tick(8);
        check("stop_no_valid", 32'(n_valid - valid_mark), 32'h0);
        check("stop_data_held", wave_data, 32'hA0);
        check("stop_status", {16'h0, wave_status}, 32'h0000_4001);

        // Control writes while active are ignored.
        reg_write(16'h8800, 32'h8000_0003);
        trig_expect(32'hA0);
        reg_write(16'h8800, 32'h8000_0007);
        check("active_status", {16'h0, wave_status}, 32'h0000_8003);
        check("active_rdata", reg_rdata, 32'h0080_0403);
        trig_expect(32'hA1);
        reg_write(16'h8800, 32'h4000_0000);

        // Second edge during the fetch is dropped.
        reg_write(16'h8800, 32'h8000_0003);
        valid_mark = n_valid;
        sb_q.push_back(32'hA0);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(15);
        check("drop_one_valid", 32'(n_valid - valid_mark), 32'h1);
        check("ovr_one", {24'h0, reg_rdata[31:24]}, {24'h0, ovr_one});
        reg_write(16'h8800, 32'h4000_0000);

        // Burst of fast edges saturates the overrun count.
        reg_write(16'h8800, 32'hA000_0003);
        sb_ignore = 1'b1;
        repeat (1200) begin
            trigger = ~trigger;
            tick(1);
        end
        trigger = 1'b0;
        tick(10);
        reg_write(16'h8800, 32'h4000_0000);
        tick(5);
        sb_ignore = 1'b0;
        check("ovr_sat", {24'h0, reg_rdata[31:24]}, {24'h0, ovr_sat});

        // Reset during FETCH.
        reg_write(16'h8800, 32'h8000_0003);
        valid_mark = n_valid;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_status", {16'h0, wave_status}, 32'h0);
        check("midrst_rdata", reg_rdata, 32'h0);
        check("midrst_data", wave_data, 32'h0);
        tick(8);
        check("midrst_no_valid", 32'(n_valid - valid_mark), 32'h0);
        reg_write(16'h8800, 32'h8000_0003);
        trig_expect(32'hA0);

        // Host write to the entry being fetched: old value plays.
        sb_q.push_back(32'hA1);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(1);
        reg_write(16'h8001, 32'h0000_00B1);
        tick(15);
        reg_write(16'h8800, 32'h4000_0000);

        // Single-entry looping table.
        reg_write(16'h8800, 32'hA000_0000);
        trig_expect(32'hA0);
        trig_expect(32'hA0);
        check("single_active", {31'b0, wave_active}, 32'h1);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
